// File: rtl/serial_divider.sv
// Bit-serial restoring divider: serial N-bit dividend (MSB first) divided by
// a 4-bit parallel divisor; serial quotient (MSB first) and parallel remainder.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   start, d          frame start request and divisor (sampled in IDLE)
//   din, din_valid    serial dividend bit and qualifier (accepted in RUN)
//   qout, qout_valid  serial quotient bit and qualifier
//   rem               remainder, valid from done until next done
//   done              one-cycle frame-complete pulse
//   busy              high while a frame is in RUN
//   dz                divide-by-zero flag, sticky until a good start
//   abort             present only when SERIAL_DIV_ABORT_EN is defined
//
// Optional feature macro: SERIAL_DIV_ABORT_EN adds the abort input.

module serial_divider #(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] d,
    input  logic       din,
    input  logic       din_valid,
`ifdef SERIAL_DIV_ABORT_EN
    input  logic       abort,
`endif
    output logic       qout,
    output logic       qout_valid,
    output logic [3:0] rem,
    output logic       done,
    output logic       busy,
    output logic       dz
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state;
    logic [3:0]      dreg;
    logic [3:0]      r;
    logic [CW-1:0]   cnt;

    logic [4:0]      t;
    logic [4:0]      diff;
    logic            ge;
    logic [3:0]      r_next;

    // r < dreg guarantees t <= 30 and the difference fits in 4 bits.
    always_comb begin
        t      = {r, din};
        ge     = (t >= {1'b0, dreg});
        diff   = t - {1'b0, dreg};
        r_next = ge ? diff[3:0] : t[3:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            dreg       <= '0;
            r          <= '0;
            cnt        <= '0;
            qout       <= 1'b0;
            qout_valid <= 1'b0;
            rem        <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            dz         <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    qout_valid <= 1'b0;
                    if (start) begin
                        if (d != 4'd0) begin
                            dreg  <= d;
                            r     <= '0;
                            cnt   <= '0;
                            dz    <= 1'b0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end else begin
                            // Zero divisor: flag and finish without a frame.
                            dz   <= 1'b1;
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
`ifdef SERIAL_DIV_ABORT_EN
                    if (abort) begin
                        r          <= '0;
                        cnt        <= '0;
                        qout_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else
`endif
                    if (din_valid) begin
                        qout       <= ge;
                        r          <= r_next;
                        qout_valid <= 1'b1;
                        cnt        <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            done  <= 1'b1;
                            rem   <= r_next;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        // Stall: qout, r and cnt hold.
                        qout_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_divider.sv
// Self-checking bench for serial_divider: directed cases plus random frames
// compared against an arithmetic quotient/remainder reference.

module tb_serial_divider;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] d;
    logic       din;
    logic       din_valid;
    logic       qout;
    logic       qout_valid;
    logic [3:0] rem;
    logic       done;
    logic       busy;
    logic       dz;
`ifdef SERIAL_DIV_ABORT_EN
    logic       abort;
`endif

    int checks = 0;
    int errors = 0;
    logic [3:0] last_rem = 4'd0;

    serial_divider #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .d          (d),
        .din        (din),
        .din_valid  (din_valid),
`ifdef SERIAL_DIV_ABORT_EN
        .abort      (abort),
`endif
        .qout       (qout),
        .qout_valid (qout_valid),
        .rem        (rem),
        .done       (done),
        .busy       (busy),
        .dz         (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] nmask();
        logic [63:0] m;
        m = (N == 64) ? '1 : ((64'd1 << N) - 64'd1);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            din_valid = 1'b1;
            din       = 1'($urandom);
            tick();
            check("idle_qv", qout_valid, 0);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_rem", rem, last_rem);
        end
        din_valid = 1'b0;
    endtask

    // Starts a frame in the current cycle and streams the dividend.
    // Ends in the done cycle so a following call starts back-to-back.
    task automatic do_frame(input logic [3:0] dv, input logic [63:0] x,
                            input int stall_at, input int stall_len,
                            input bit poke);
        logic [63:0] q;
        logic        hold;
        start     = 1'b1;
        d         = dv;
        din_valid = 1'b0;
        tick();
        start = 1'b0;
        d     = 4'($urandom);
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_dz", dz, 0);
        check("start_qv", qout_valid, 0);
        check("start_rem_hold", rem, last_rem);
        q = '0;
        for (int i = 0; i < N; i++) begin
            din       = x[N-1-i];
            din_valid = 1'b1;
            tick();
            din_valid = 1'b0;
            check("bit_qv", qout_valid, 1);
            q = {q[62:0], qout};
            if (i < N - 1) begin
                check("bit_busy", busy, 1);
                check("bit_done", done, 0);
            end
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    hold  = qout;
                    din   = 1'($urandom);
                    start = poke;
                    d     = 4'($urandom_range(0, 15));
                    tick();
                    start = 1'b0;
                    check("stall_qv", qout_valid, 0);
                    check("stall_qout", qout, hold);
                    check("stall_busy", busy, 1);
                    check("stall_done", done, 0);
                end
            end
        end
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("quotient", q, x / {60'd0, dv});
        check("remainder", rem, x % {60'd0, dv});
        last_rem = 4'(x % {60'd0, dv});
    endtask

    task automatic dz_case();
        start = 1'b1;
        d     = 4'd0;
        tick();
        start = 1'b0;
        d     = 4'd9;
        check("dz_flag", dz, 1);
        check("dz_done", done, 1);
        check("dz_busy", busy, 0);
        check("dz_qv", qout_valid, 0);
        check("dz_rem", rem, last_rem);
        tick();
        check("dz_done_pulse", done, 0);
        check("dz_sticky", dz, 1);
        check("dz_busy2", busy, 0);
        check("dz_qv2", qout_valid, 0);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        d         = 4'd0;
        din       = 1'b0;
        din_valid = 1'b0;
`ifdef SERIAL_DIV_ABORT_EN
        abort     = 1'b0;
`endif
        tick();
        tick();
        check("rst_qout", qout, 0);
        check("rst_qv", qout_valid, 0);
        check("rst_rem", rem, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_dz", dz, 0);
        rst = 1'b1;
        idle(2);

        // 100 / 3 = 33 rem 1
        do_frame(4'd3, 64'd100, -1, 0, 1'b0);
        idle(1);

        // 255 / 1, then 255 / 15 back-to-back
        do_frame(4'd1, 64'hFF, -1, 0, 1'b0);
        do_frame(4'd15, 64'hFF, -1, 0, 1'b0);
        idle(2);

        // divide by zero, then a good start clears dz
        dz_case();
        do_frame(4'd5, 64'd77, -1, 0, 1'b0);
        idle(1);

        // 200 / 7 = 28 rem 4 with a 3-cycle stall after the 4th bit
        do_frame(4'd7, 64'd200, 3, 3, 1'b1);
        idle(1);

        // reset mid-frame after 5 bits
        start = 1'b1;
        d     = 4'd1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din       = 1'b1;
            din_valid = 1'b1;
            tick();
        end
        check("pre_rst_busy", busy, 1);
        rst   = 1'b0;
        start = 1'b1;
        d     = 4'd4;
        tick();
        rst       = 1'b1;
        start     = 1'b0;
        din_valid = 1'b0;
        check("mrst_qout", qout, 0);
        check("mrst_qv", qout_valid, 0);
        check("mrst_rem", rem, 0);
        check("mrst_done", done, 0);
        check("mrst_busy", busy, 0);
        check("mrst_dz", dz, 0);
        last_rem = 4'd0;
        idle(1);
        do_frame(4'd3, 64'd100, -1, 0, 1'b0);
        idle(1);

`ifdef SERIAL_DIV_ABORT_EN
        do_frame(4'd6, 64'd101, -1, 0, 1'b0);
        idle(1);
        start = 1'b1;
        d     = 4'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din       = 1'b1;
            din_valid = 1'b1;
            tick();
        end
        abort     = 1'b1;
        din_valid = 1'b1;
        tick();
        abort     = 1'b0;
        din_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_qv", qout_valid, 0);
        check("abort_rem", rem, last_rem);
        idle(2);
        do_frame(4'd9, 64'd250, -1, 0, 1'b0);
        idle(1);
`endif

        // random frames with random stalls, gaps and zero divisors
        for (int f = 0; f < 30; f++) begin
            logic [63:0] x;
            logic [3:0]  dv;
            int          st;
            x  = {32'($urandom), 32'($urandom)} & nmask();
            dv = 4'($urandom_range(1, 15));
            st = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, N - 2));
            if ($urandom_range(0, 7) == 0) begin
                dz_case();
            end
            do_frame(dv, x, st, int'($urandom_range(1, 4)), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                idle(int'($urandom_range(1, 3)));
            end
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_divider.md
# serial_divider

Bit-serial restoring divider: accepts an N-bit dividend one bit per cycle, MSB first, divides it by a 4-bit parallel divisor, and returns the quotient one bit per cycle, MSB first, plus a parallel 4-bit remainder. It is the inverse stage to the team's bit-serial multiplier (serial operand times 4-bit parallel operand). It uses the same single-bit datapath style: a shift/compare/subtract cell with registered state. A small FSM handles framing, stalls and the divide-by-zero case.

## Interface
Parameters:
- N, default 8: dividend (and quotient) length in bits per frame; legal range 2..64.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low; clock clk.
- start  in  1  frame start request; sampled only in IDLE.
- d  in  4  divisor; sampled with start.
- din  in  1  serial dividend bit, MSB first.
- din_valid  in  1  din qualifier; accepted only in RUN.
- qout  out  1  serial quotient bit, MSB first.
- qout_valid  out  1  qout qualifier.
- rem  out  4  remainder; valid from the done cycle until the next accepted start.
- done  out  1  one-cycle pulse, frame complete.
- busy  out  1  high in RUN.
- dz  out  1  divide-by-zero flag.
- abort  in  1  only present when SERIAL_DIV_ABORT_EN is defined.

## Operation
- States: IDLE, RUN.
- Registers: dreg[3:0], r[3:0] partial remainder, cnt (width clog2(N)).
- IDLE with start=1 and d!=0:
  - dreg<=d, r<=0, cnt<=0, dz<=0.
  - Go to RUN.
- IDLE with start=1 and d==0:
  - dz<=1, done<=1 for one cycle.
  - Stay in IDLE.
  - No qout_valid is produced.
- RUN, accepted bit (din_valid=1):
  - t[4:0]={r,din}.
  - If t>=dreg: qout<=1 and r<=t-dreg; else qout<=0 and r<=t[3:0].
  - qout_valid<=1, cnt<=cnt+1.
- Width rule: r<dreg<=15 always holds, so t<=30 fits 5 bits and the result fits 4 bits. No overflow case exists.
- RUN with din_valid=0:
  - Stall. qout_valid<=0, qout holds its value, r and cnt hold.
- Last bit (accepted while cnt==N-1):
  - done<=1, rem<=final r.
  - Next state IDLE.
- start in RUN is ignored. din_valid in IDLE is ignored.
- start in the done cycle (state is already IDLE) is accepted normally.
- dz stays set until the next accepted start with d!=0.
- rem holds its value until the next done; it is not cleared by start.

## Timing
- Reset (rst=0 at an edge) overrides all other inputs, including in mid-frame. After that edge:
  - State is IDLE.
  - qout=0, qout_valid=0, rem=0, done=0, busy=0, dz=0.
  - Internal r, dreg and cnt are 0.
- busy=1 from the cycle after an accepted start through the cycle of the last accepted bit. busy=0 in the done cycle.
- Latency: qout for a bit accepted at edge k is visible after edge k, i.e. 1 cycle.
- done, rem and the last qout_valid assert in the same cycle.
- Minimum frame time: N+1 cycles from the start edge to the done cycle, with no stalls.
- Back-to-back: a start asserted in the done cycle begins the next frame with no bubble.
- dz case: done pulses in the cycle after the start edge; busy never rises.

## Configuration
- SERIAL_DIV_ABORT_EN defined:
  - Adds the abort input.
  - abort=1 in RUN: the next state is IDLE, r<=0, cnt<=0, qout_valid<=0. No done pulse; rem keeps its old value.
  - abort has priority over din_valid in the same cycle.
  - abort in IDLE has no effect.
- SERIAL_DIV_ABORT_EN not defined:
  - The abort port does not exist.
  - A frame ends only on completion or reset.

## Test plan
- d=3, N=8, dividend 100 (01100100) streamed with no stall -> qout stream 0,0,1,0,0,0,0,1 (33). In the done cycle rem=1, done=1 for exactly one cycle, busy=0.
- d=1, dividend 0xFF -> quotient 0xFF, rem=0. Then d=15, dividend 0xFF started in the done cycle -> quotient 17 (00010001), rem=0, no idle bubble.
- d=0 start -> dz=1 and done=1 one cycle after start. qout_valid and busy never assert. A following start with d=5 clears dz.
- d=7, dividend 200 with din_valid low for 3 cycles after the 4th bit -> quotient 28 (00011100) with a 3-cycle gap in qout_valid, rem=4. A start pulse during the stall is ignored.
- Reset asserted after 5 bits of a frame -> next cycle all outputs 0, state IDLE. A fresh frame (d=3, dividend 100) then gives 33 rem 1.
- With SERIAL_DIV_ABORT_EN defined: abort after 3 bits with din_valid=1 in the same cycle -> busy=0 next cycle, no done pulse, rem unchanged from the previous frame. A following frame computes correctly.
